// File: rtl/dir_button_ctrl_if.sv
// Button-side signal bundle: raw button in, debounced level/strobes/direction out.
// master = debouncer side, slave = button source and downstream consumers.
interface dir_button_ctrl_if;
  logic btn_raw;
  logic count_up;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;

  modport master (
    input  btn_raw,
    output count_up,
    output btn_level,
    output press_pulse,
    output release_pulse
  );

  modport slave (
    output btn_raw,
    input  count_up,
    input  btn_level,
    input  press_pulse,
    input  release_pulse
  );
endinterface

// File: rtl/dir_button_ctrl.sv
// Button debouncer producing debounced level, press/release strobes and count direction.
// Latency N+2 edges per accepted change; no backpressure. Macro DIR_TOGGLE_EN: toggle direction per press.
module dir_button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic               clock,
  input  logic               reset,
  dir_button_ctrl_if.master  btn
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          sync1, sync2;
  logic          level_q, level_nxt;
  logic          press_q, press_nxt;
  logic          release_q, release_nxt;
  logic          count_up_q, count_up_nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      count_up_q <= 1'b1;
    end else begin
      sync1      <= btn.btn_raw;
      sync2      <= sync1;
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      level_q    <= level_nxt;
      press_q    <= press_nxt;
      release_q  <= release_nxt;
      count_up_q <= count_up_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (sync2) begin
          state_nxt = WAIT_HIGH;
          cnt_nxt   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync2) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HIGH: begin
        if (!sync2) begin
          state_nxt = WAIT_LOW;
          cnt_nxt   = '0;
        end
      end
      WAIT_LOW: begin
        if (sync2) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Level is held high through WAIT_LOW until the release is qualified.
    level_nxt = (state_nxt == HIGH) || (state_nxt == WAIT_LOW);

`ifdef DIR_TOGGLE_EN
    count_up_nxt = count_up_q ^ press_nxt;
`else
    count_up_nxt = ~level_nxt;
`endif
  end

  assign btn.btn_level     = level_q;
  assign btn.press_pulse   = press_q;
  assign btn.release_pulse = release_q;
  assign btn.count_up      = count_up_q;

endmodule

// File: tb/tb_dir_button_ctrl.sv
// Directed bench for dir_button_ctrl with DEBOUNCE_CYCLES=4 (accept after 6 edges).
module tb_dir_button_ctrl;

  localparam int N = 4;
`ifdef DIR_TOGGLE_EN
  localparam bit TOG = 1'b1;
`else
  localparam bit TOG = 1'b0;
`endif

  logic clock;
  logic reset;
  int   compared;
  int   mismatched;
  logic exp_cu;

  dir_button_ctrl_if bi ();

  dir_button_ctrl #(.DEBOUNCE_CYCLES(N)) dut (
    .clock (clock),
    .reset (reset),
    .btn   (bi.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Drives a new level and walks edges 0..N+3, checking the accept lands exactly at edge N+2.
  task automatic test_accept(input logic lvl, input string nm);
    bi.btn_raw = lvl;
    for (int e = 0; e <= N + 3; e++) begin
      tick();
      if (e == N + 2) exp_cu = lvl ? (TOG ? ~exp_cu : 1'b0) : (TOG ? exp_cu : 1'b1);
      compared++;
      if (bi.press_pulse !== (lvl && e == N + 2) || bi.release_pulse !== (!lvl && e == N + 2) ||
          bi.btn_level !== ((e >= N + 2) ? lvl : ~lvl) || bi.count_up !== exp_cu) begin
        mismatched++;
        $display("FAIL %s edge %0d: got press=%b rel=%b lvl=%b cu=%b, want press=%b rel=%b lvl=%b cu=%b",
                 nm, e, bi.press_pulse, bi.release_pulse, bi.btn_level, bi.count_up,
                 lvl && e == N + 2, !lvl && e == N + 2, (e >= N + 2) ? lvl : ~lvl, exp_cu);
      end
    end
  endtask

  task automatic test_reset;
    bi.btn_raw = 1'b1;
    reset = 1'b1;
    exp_cu = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if (bi.count_up !== 1'b1 || bi.btn_level !== 1'b0 || bi.press_pulse !== 1'b0 || bi.release_pulse !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_hold cyc %0d: got cu=%b lvl=%b press=%b rel=%b, want 1 0 0 0",
                 i, bi.count_up, bi.btn_level, bi.press_pulse, bi.release_pulse);
      end
    end
    reset = 1'b0;
    test_accept(1'b1, "reset_then_press");
  endtask

  task automatic test_release_second_press;
    test_accept(1'b0, "release1");
    test_accept(1'b1, "press2");
    test_accept(1'b0, "release2");
  endtask

  task automatic test_bounce;
    logic [7:0] pat;
    pat = 8'b1110_1110;
    for (int i = 7; i >= 0; i--) begin
      bi.btn_raw = pat[i];
      tick();
      compared++;
      if (bi.press_pulse !== 1'b0 || bi.release_pulse !== 1'b0 || bi.btn_level !== 1'b0) begin
        mismatched++;
        $display("FAIL bounce step %0d: got press=%b rel=%b lvl=%b, want 0 0 0",
                 7 - i, bi.press_pulse, bi.release_pulse, bi.btn_level);
      end
    end
    // The trailing low of the bounce pattern must also be shaken out before the steady press.
    test_accept(1'b1, "bounce_press");
  endtask

  task automatic test_hold;
    int presses;
    presses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      presses += int'(bi.press_pulse) + int'(bi.release_pulse);
    end
    compared++;
    if (presses !== 0 || bi.btn_level !== 1'b1 || bi.count_up !== exp_cu) begin
      mismatched++;
      $display("FAIL hold: got strobes=%0d lvl=%b cu=%b, want 0 1 %b", presses, bi.btn_level, bi.count_up, exp_cu);
    end
    test_accept(1'b0, "hold_release");
  endtask

  task automatic test_reset_mid;
    bi.btn_raw = 1'b1;
    for (int e = 0; e <= 4; e++) tick();
    // Counter is 2 in WAIT_HIGH here; reset lands mid-cycle.
    #2 reset = 1'b1;
    #1;
    exp_cu = 1'b1;
    compared++;
    if (bi.count_up !== 1'b1 || bi.btn_level !== 1'b0 || bi.press_pulse !== 1'b0 || bi.release_pulse !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid_async: got cu=%b lvl=%b press=%b rel=%b, want 1 0 0 0",
               bi.count_up, bi.btn_level, bi.press_pulse, bi.release_pulse);
    end
    tick();
    reset = 1'b0;
    test_accept(1'b1, "post_reset_press");
  endtask

  task automatic test_back_to_back;
    test_accept(1'b0, "b2b_release");
    test_accept(1'b1, "b2b_press");
    test_accept(1'b0, "b2b_release2");
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    bi.btn_raw = 1'b0;
    exp_cu     = 1'b1;
    #1;
    compared++;
    if (bi.count_up !== 1'b1 || bi.btn_level !== 1'b0 || bi.press_pulse !== 1'b0 || bi.release_pulse !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_initial: got cu=%b lvl=%b press=%b rel=%b, want 1 0 0 0",
               bi.count_up, bi.btn_level, bi.press_pulse, bi.release_pulse);
    end
    tick();
    test_reset();
    test_release_second_press();
    test_bounce();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
